seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_glyph_decoder.sv | 34 +++
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 8-digit seven-segment scan driver:
// code field positions, glyph indices and blank/off patterns.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CODE_W     = 6;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam int EN_BIT    = 5;
  localparam int GLYPH_MSB = 4;
  localparam int GLYPH_LSB = 1;
  localparam int DP_BIT    = 0;

  localparam logic [3:0] GLYPH_A    = 4'd10;
  localparam logic [3:0] GLYPH_B    = 4'd11;
  localparam logic [3:0] GLYPH_C    = 4'd12;
  localparam logic [3:0] GLYPH_E    = 4'd13;
  localparam logic [3:0] GLYPH_J    = 4'd14;
  localparam logic [3:0] GLYPH_DASH = 4'd15;

  localparam logic [6:0]            SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;

  typedef logic [CODE_W-1:0] code_t;

  // Slot 0 is the leftmost digit, which sits on the top anode bit.
  function automatic logic [NUM_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(idx)));
  endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational glyph index to active-low {g,f,e,d,c,b,a} segment decoder.
// Also reused by the display manager's bench to check codes.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] glyph_idx,
  output logic [6:0] seg
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    seg = SEG_BLANK;
    case (glyph_idx)
      4'd0:       seg = 7'b1000000;
      4'd1:       seg = 7'b1111001;
      4'd2:       seg = 7'b0100100;
      4'd3:       seg = 7'b0110000;
      4'd4:       seg = 7'b0011001;
      4'd5:       seg = 7'b0010010;
      4'd6:       seg = 7'b0000010;
      4'd7:       seg = 7'b1111000;
      4'd8:       seg = 7'b0000000;
      4'd9:       seg = 7'b0010000;
      GLYPH_A:    seg = 7'b0001000;
      GLYPH_B:    seg = 7'b0000011;
      GLYPH_C:    seg = 7'b1000110;
      GLYPH_E:    seg = 7'b0000110;
      GLYPH_J:    seg = 7'b1100001;
      GLYPH_DASH: seg = 7'b0111111;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with per-frame
// shadow capture and inter-digit blanking. Optional blinking: SEG7_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CODE_W-1:0]     d1,
  input  logic [CODE_W-1:0]     d2,
  input  logic [CODE_W-1:0]     d3,
  input  logic [CODE_W-1:0]     d4,
  input  logic [CODE_W-1:0]     d5,
  input  logic [CODE_W-1:0]     d6,
  input  logic [CODE_W-1:0]     d7,
  input  logic [CODE_W-1:0]     d8,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  code_t                 shadow_q [NUM_DIGITS];
  code_t                 shadow_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic       slot_end, frame_end, in_blank, blink_dark, lit;
  code_t      cur_code;
  logic [6:0] glyph_seg;

  assign slot_end  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign frame_end = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign in_blank  = (cnt_q < CNT_W'(BLANK_CYCLES));
  assign cur_code  = shadow_q[idx_q];

  seg7_glyph_decoder u_glyph (
    .glyph_idx (cur_code[GLYPH_MSB:GLYPH_LSB]),
    .seg       (glyph_seg)
  );

`ifdef SEG7_BLINK_EN
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [5:0]            frame_q, frame_d;

  always_comb begin
    mask_d  = mask_q;
    frame_d = frame_q;
    if (frame_end) begin
      mask_d  = blink_mask;
      frame_d = frame_q + 6'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mask_q  <= '0;
      frame_q <= '0;
    end else begin
      mask_q  <= mask_d;
      frame_q <= frame_d;
    end
  end

  assign blink_dark = frame_q[5] & mask_q[idx_q];
`else
  assign blink_dark = 1'b0;
`endif

  always_comb begin
    cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d    = slot_end ? idx_q + IDX_W'(1) : idx_q;
    shadow_d = shadow_q;
    if (frame_end) begin
      shadow_d = '{d1, d2, d3, d4, d5, d6, d7, d8};
    end

    lit  = cur_code[EN_BIT] & ~in_blank & ~blink_dark;
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d  = anode_for(idx_q);
      seg_d = glyph_seg;
      dp_d  = cur_code[DP_BIT];
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      // NOTE: the shadow store is reset on purpose; all-zero codes keep the display dark until the first capture.
      shadow_q <= '{default: '0};
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
